// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and default widths for the APB dual-master bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int c_DEFAULT_ADDR_W = 32;
    localparam int c_DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; the requester that was not granted
//               last wins a tie. The parent owns the last_grant register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (&req) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_dual_master_bridge.sv
// ============================================================================
// Module      : apb_dual_master_bridge
// Description : Shares one APB bus between two requesters with round-robin
//               arbitration, address-bit slave decode and a PREADY timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_dual_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = c_DEFAULT_ADDR_W,
    parameter int DATA_W  = c_DEFAULT_DATA_W,
    parameter int SEL_BIT = 15,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [1:0]          req,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic                PENABLE,
    output logic [1:0]          PSEL,
    input  logic [DATA_W-1:0]   PRDATA0,
    input  logic [DATA_W-1:0]   PRDATA1,
    input  logic                PREADY0,
    input  logic                PREADY1,
    input  logic                PSLVERR0,
    input  logic                PSLVERR1
);

    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic                r_idx;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [1:0]          r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic [1:0]          w_grant;
    logic                w_arb;
    logic                w_win;
    logic                w_sel;
    logic                w_ready;
    logic                w_timeout;
    logic                w_complete;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_grant (r_last),
        .grant      (w_grant)
    );

    assign w_win      = w_grant[1];
    assign w_sel      = r_paddr[SEL_BIT];
    assign w_ready    = w_sel ? PREADY1 : PREADY0;
    // Timeout fires on the TIMEOUT-th ACCESS cycle that still lacks PREADY.
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST) && !w_ready;
    assign w_complete = (r_state == ACCESS) && (w_ready || w_timeout);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_arb  = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
                if (|req) w_next = SETUP;
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                if (w_complete) begin
                    w_arb  = 1'b1;
                    w_next = (|req) ? SETUP : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign gnt     = w_arb ? w_grant : 2'b00;
    assign PSEL    = (r_state == SETUP || r_state == ACCESS) ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    assign PENABLE = (r_state == ACCESS);
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PWRITE  = r_pwrite;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign err     = r_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last   <= 1'b1;
            r_idx    <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 2'b00;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 2'b00;
            if (|gnt) begin
                r_last   <= w_win;
                r_idx    <= w_win;
                r_paddr  <= w_win ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                r_pwdata <= w_win ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                r_pwrite <= w_win ? req_write[1] : req_write[0];
            end
            if (r_state == SETUP) begin
                r_cnt <= '0;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_complete) begin
                r_done <= r_idx ? 2'b10 : 2'b01;
                if (w_ready) begin
                    r_err <= w_sel ? PSLVERR1 : PSLVERR0;
                    if (!r_pwrite) r_rdata <= w_sel ? PRDATA1 : PRDATA0;
                end else begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_dual_master_bridge.sv
// ============================================================================
// Module      : tb_apb_dual_master_bridge
// Description : Vector table plus corner-case sequences with a done scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_dual_master_bridge;

    localparam int c_AW  = 32;
    localparam int c_DW  = 32;
    localparam int c_SEL = 15;
    localparam int c_TO  = 16;

    logic                PCLK    = 1'b0;
    logic                PRESETn = 1'b1;
    logic [1:0]          req       = 2'b00;
    logic [1:0]          req_write = 2'b00;
    logic [2*c_AW-1:0]   req_addr  = '0;
    logic [2*c_DW-1:0]   req_wdata = '0;
    logic [1:0]          gnt, done, PSEL;
    logic [c_DW-1:0]     rdata, PWDATA, PRDATA0, PRDATA1;
    logic [c_AW-1:0]     PADDR;
    logic                err, PWRITE, PENABLE;
    logic                PREADY0, PREADY1, PSLVERR0, PSLVERR1;

    // Slave model: selected slave answers after s_wait stalls (never if stuck);
    // the other slave drives opposite values so any leak shows up.
    logic [c_DW-1:0]     s_prd   = '0;
    logic                s_err   = 1'b0;
    int                  s_wait  = 0;
    logic                s_stuck = 1'b0;
    int                  acnt;

    typedef struct {
        logic            who;
        logic            wr;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [31:0]     prd;
        logic            slverr;
        int              waitn;
        logic            stuck;
        logic [1:0]      exp_psel;
        logic [31:0]     exp_rdata;
        logic            exp_err;
        int              exp_lat;
    } vec_t;

    typedef struct {
        logic [1:0]      done;
        logic [31:0]     rdata;
        logic            err;
    } exp_t;

    vec_t vecs[7];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    apb_dual_master_bridge #(
        .ADDR_W  (c_AW),
        .DATA_W  (c_DW),
        .SEL_BIT (c_SEL),
        .TIMEOUT (c_TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA0   (PRDATA0),
        .PRDATA1   (PRDATA1),
        .PREADY0   (PREADY0),
        .PREADY1   (PREADY1),
        .PSLVERR0  (PSLVERR0),
        .PSLVERR1  (PSLVERR1)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY0  = PADDR[c_SEL] ? 1'b1 : (!s_stuck && (acnt >= s_wait));
    assign PREADY1  = PADDR[c_SEL] ? (!s_stuck && (acnt >= s_wait)) : 1'b1;
    assign PRDATA0  = PADDR[c_SEL] ? ~s_prd : s_prd;
    assign PRDATA1  = PADDR[c_SEL] ? s_prd : ~s_prd;
    assign PSLVERR0 = PADDR[c_SEL] ? ~s_err : s_err;
    assign PSLVERR1 = PADDR[c_SEL] ? s_err : ~s_err;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) acnt <= 0;
        else if (PENABLE && !(PADDR[c_SEL] ? PREADY1 : PREADY0)) acnt <= acnt + 1;
        else acnt <= 0;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] d, input logic [31:0] rd, input logic e);
        exp_t t;
        t.done  = d;
        t.rdata = rd;
        t.err   = e;
        return t;
    endfunction

    always @(negedge PCLK) begin : mon
        exp_t e;
        if (PRESETn && done !== 2'b00) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 128'(done), 128'(0));
            end else begin
                e = sbq.pop_front();
                chk("done_idx", 128'(done), 128'(e.done));
                chk("rdata", 128'(rdata), 128'(e.rdata));
                chk("err", 128'(err), 128'(e.err));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int         lat;
        logic [1:0] oh;
        oh = v.who ? 2'b10 : 2'b01;
        @(negedge PCLK);
        s_prd   = v.prd;
        s_err   = v.slverr;
        s_wait  = v.waitn;
        s_stuck = v.stuck;
        req_write[v.who]                    = v.wr;
        req_addr[int'(v.who)*c_AW +: c_AW]  = v.addr;
        req_wdata[int'(v.who)*c_DW +: c_DW] = v.wdata;
        req[v.who]                          = 1'b1;
        #1;
        chk("gnt", 128'(gnt), 128'(oh));
        sbq.push_back(mk_exp(oh, v.exp_rdata, v.exp_err));
        @(negedge PCLK);
        req       = 2'b00;
        req_addr  = '1;
        req_wdata = '1;
        req_write = 2'b11;
        chk("setup_psel_pen", 128'({PSEL, PENABLE}), 128'({v.exp_psel, 1'b0}));
        chk("setup_paddr", 128'(PADDR), 128'(v.addr));
        chk("setup_pwrite", 128'(PWRITE), 128'(v.wr));
        chk("setup_pwdata", 128'(PWDATA), 128'(v.wdata));
        lat = 1;
        while (lat < 40) begin
            @(negedge PCLK);
            lat++;
            if (done !== 2'b00) break;
            if (lat == 2) chk("access_penable", 128'(PENABLE), 128'(1));
            if (PENABLE)
                chk("access_hold", 128'({PSEL, PWRITE, PADDR, PWDATA}),
                    128'({v.exp_psel, v.wr, v.addr, v.wdata}));
        end
        chk("latency", 128'(lat), 128'(v.exp_lat));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        int         n;
        int         last;
        logic       exp_who;
        logic       got;

        //           who   wr    addr           wdata          prd            serr  wt  stuck psel   exp_rdata      err   lat
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0035, 32'hDEAD_0000, 1'b0, 0, 1'b0, 2'b01, 32'h0000_0000, 1'b0, 3};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_8000, 32'h0000_0000, 32'h0000_00A5, 1'b0, 0, 1'b0, 2'b10, 32'h0000_00A5, 1'b0, 3};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0010, 32'h1111_2222, 32'h1234_5678, 1'b0, 3, 1'b0, 2'b01, 32'h1234_5678, 1'b0, 6};
        vecs[3] = '{1'b1, 1'b1, 32'h0001_8004, 32'h0000_CAFE, 32'h0000_0BAD, 1'b1, 1, 1'b0, 2'b10, 32'h1234_5678, 1'b1, 4};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_FFFF, 1'b0, 0, 1'b1, 2'b01, 32'h0000_0000, 1'b1, 18};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_7FFF, 32'h0000_0000, 32'h0000_0077, 1'b0, 0, 1'b0, 2'b01, 32'h0000_0077, 1'b0, 3};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_8000, 32'h0000_0000, 32'h0000_0099, 1'b0, 0, 1'b0, 2'b10, 32'h0000_0099, 1'b0, 3};

        #1 PRESETn = 1'b0;
        #2;
        chk("reset_outputs", 128'({PSEL, PENABLE, PADDR, PWDATA, PWRITE, gnt, done, rdata, err}), 128'(0));
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters held: grants alternate starting with 1 (0 went last).
        @(negedge PCLK);
        s_prd = 32'h55; s_err = 1'b0; s_wait = 0; s_stuck = 1'b0;
        req_write = 2'b00;
        req_addr  = {32'h0000_8000, 32'h0000_0000};
        req       = 2'b11;
        exp_who = 1'b1; n = 0; last = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            if (c > 0) @(negedge PCLK);
            #1;
            if (gnt !== 2'b00) begin
                chk("rr_gnt", 128'(gnt), 128'(exp_who ? 2'b10 : 2'b01));
                if (n > 0) chk("rr_spacing", 128'(c - last), 128'(2));
                sbq.push_back(mk_exp(exp_who ? 2'b10 : 2'b01, 32'h55, 1'b0));
                last = c;
                n++;
                exp_who = !exp_who;
            end
        end
        chk("rr_count", 128'(n), 128'(6));
        @(negedge PCLK);
        req = 2'b00;
        repeat (5) @(negedge PCLK);

        // Asynchronous reset in the middle of an ACCESS phase drops the transfer.
        s_wait = 5; s_prd = 32'h1;
        req_addr = {32'h0, 32'h0000_0100};
        req = 2'b01;
        #1 chk("pre_rst_gnt", 128'(gnt), 128'(2'b01));
        @(negedge PCLK);
        req = 2'b00;
        @(negedge PCLK);
        chk("pre_rst_access", 128'(PENABLE), 128'(1));
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_outputs", 128'({PSEL, PENABLE, PADDR, PWDATA, PWRITE, gnt, done, rdata, err}), 128'(0));
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (6) begin
            @(negedge PCLK);
            chk("no_done_after_rst", 128'(done), 128'(0));
        end

        s_wait = 0; s_prd = 32'h3C;
        req_addr = {32'h0000_8000, 32'h0000_0004};
        req = 2'b11;
        #1 chk("rst_first_gnt", 128'(gnt), 128'(2'b01));
        sbq.push_back(mk_exp(2'b01, 32'h3C, 1'b0));
        @(negedge PCLK);
        req[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            #1;
            if (gnt !== 2'b00) begin
                chk("rst_second_gnt", 128'(gnt), 128'(2'b10));
                sbq.push_back(mk_exp(2'b10, 32'h3C, 1'b0));
                got = 1'b1;
                break;
            end
        end
        chk("rst_second_seen", 128'(got), 128'(1));
        @(negedge PCLK);
        req = 2'b00;

        repeat (8) @(negedge PCLK);
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_dual_master_bridge.md
# apb_dual_master_bridge

APB master bridge letting two on-chip requesters share one APB bus to the two peripherals (adder peripheral on PSEL[0], second peripheral on PSEL[1]). Arbitrates round-robin, sequences SETUP/ACCESS phases, decodes the target peripheral from one address bit and returns read data and error status to the granted requester. Includes a PREADY timeout so a hung slave cannot lock the bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_BIT, 15, PADDR bit selecting peripheral (0 → PSEL[0], 1 → PSEL[1])
- TIMEOUT, 16, max ACCESS cycles without PREADY; 0 disables timeout
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req  in  2  per-requester transfer request, held until gnt
- req_write  in  2  per-requester direction (1 = write)
- req_addr  in  2×ADDR_W  flat, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2×DATA_W  flat, same packing
- gnt  out  2  one-hot, one-cycle accept pulse; request fields sampled this cycle
- done  out  2  one-hot, one-cycle completion pulse
- rdata  out  DATA_W  read data, valid with done, held until next done
- err  out  1  error status, valid with done, held until next done
- PADDR  out  ADDR_W; PWRITE  out  1; PWDATA  out  DATA_W; PENABLE  out  1; PSEL  out  2
- PRDATA0, PRDATA1  in  DATA_W each; PREADY0, PREADY1  in  1 each; PSLVERR0, PSLVERR1  in  1 each

## Operation
- FSM: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0. If any req: round-robin pick, gnt[i]=1 (combinational from req and state), latch addr/wdata/write and index, → SETUP.
- SETUP: PSEL[PADDR[SEL_BIT]]=1, PENABLE=0, always → ACCESS next cycle.
- ACCESS: PENABLE=1. Selected PREADY=1 → complete: capture rdata (PRDATA of selected slave on reads; unchanged on writes), err=selected PSLVERR, done[i] next cycle. On completion, if any req: arbitrate, gnt same cycle, → SETUP (back-to-back, PSEL stays high only if same slave); else → IDLE.
- Round-robin: last_grant register; requester ≠ last_grant wins ties; single requester always wins. last_grant resets to 1 (requester 0 wins first).
- Timeout: counter counts ACCESS cycles, clears on SETUP. If counter reaches TIMEOUT with PREADY=0: abort, done[i] with err=1, rdata=0, same next-state rule as completion. Counter width $clog2(TIMEOUT+1).
- PADDR/PWRITE/PWDATA stable SETUP through completion; retain last values in IDLE.
- Requesters may drop fields after gnt; req asserted in the gnt cycle with no further intent must be deasserted next cycle.

## Timing
- Reset: all outputs 0 (PSEL, PENABLE, PADDR, PWDATA, PWRITE, gnt, done, rdata, err); state IDLE; counter 0.
- Zero-wait transfer: gnt cycle 0, SETUP cycle 1, ACCESS cycle 2, done cycle 3.
- Each PREADY=0 ACCESS cycle adds one cycle.
- Back-to-back: next SETUP in cycle 3 concurrent with previous done; bus throughput one transfer per 2 cycles.
- Reset mid-transfer: immediate return to reset values; transfer dropped, no done.
- PREADY/PSLVERR of non-selected slave ignored.

## Structure
- Package apb_pkg: state_t enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), default ADDR_W/DATA_W constants.
- Sub-module rr_arbiter2: 2-way round-robin, inputs req[1:0], last_grant; output one-hot grant; last_grant update in parent on gnt.

## Test plan
- Reset, req[0] write addr 0x0000_0000 data 0x0000_0035 → gnt[0] cycle 0, PSEL=2'b01 cycles 1–2, PENABLE cycle 2, done[0] cycle 3, err=0.
- req[1] read addr 0x0000_8000, PRDATA1=0xA5 → PSEL=2'b10, done[1] with rdata=0xA5.
- req=2'b11 held continuously → grants alternate 0,1,0,1; SETUPs every 2 cycles; no starvation.
- Slave 0 holds PREADY0=0 for 3 cycles → ACCESS lasts 4 cycles, done 3 cycles late, address/data stable throughout.
- PREADY0 stuck 0, TIMEOUT=16 → abort after 16 ACCESS cycles, done with err=1, rdata=0; next req proceeds normally.
- PRESETn low during ACCESS → all outputs 0 asynchronously, no done; after release, req[0] wins first.
